// File: rtl/coproc_sequencer_pkg.sv
// Purpose: shared opcodes, FSM state encoding and reset constants for coproc_sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package coproc_sequencer_pkg;

    // Header opcode, taken from hdr[7:6]
    localparam logic [1:0] OP_SETCTL = 2'b00;
    localparam logic [1:0] OP_DATA   = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    // Coprocessor default mode after reset
    localparam logic [5:0] CTRL_RESET = 6'b001100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5,
        ST_CLEAR   = 3'd6
    } state_t;

    // Byte counter width: ceil(log2(max bytes))+1. The same counter also times
    // the WAIT phase, so it is widened if PIPE_LAT would not fit.
    function automatic int cnt_width(input int din_w, input int dout_w, input int lat);
        int nb;
        int wb;
        int wl;
        nb = ((din_w > dout_w) ? din_w : dout_w) / 8;
        wb = $clog2(nb) + 1;
        wl = $clog2(lat) + 1;
        return (wb > wl) ? wb : wl;
    endfunction

endpackage

// File: rtl/coproc_sequencer_byte_serializer.sv
// Purpose: emits a WIDTH-bit word as WIDTH/8 bytes, MSB first, over a valid/ready link.
// Latency: first byte valid the cycle after load; done strobes in the cycle the last byte is accepted.
// Backpressure: byte and index hold while tx_ready is low; load is only issued while idle.
// Ports: clk, rst (async, active-high); load/load_dat capture the word;
//        tx_data/tx_valid/tx_ready byte handshake; done = last byte accepted this cycle.
module coproc_sequencer_byte_serializer #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(NB) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    logic [WIDTH-1:0] buf_q, buf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             accept;

    always_comb begin
        buf_d  = buf_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        accept = vld_q && tx_ready;
        done   = accept && (idx_q == LAST_IDX);
        if (load) begin
            buf_d = load_dat;
            idx_d = '0;
            vld_d = 1'b1;
        end else if (accept) begin
            // Current byte always sits in the top 8 bits
            buf_d = buf_q << 8;
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                vld_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    assign tx_data  = vld_q ? buf_q[WIDTH-1 -: 8] : 8'h00;
    assign tx_valid = vld_q;

endmodule

// File: rtl/coproc_sequencer.sv
// Purpose: parses the UART rx byte stream into control writes and data words, issues words to the
//          coprocessor, captures the result after PIPE_LAT cycles and serializes it back to the tx side.
// Latency: cp_din_valid 1 cycle after the last data byte; result latched PIPE_LAT cycles later; idle at +2+PIPE_LAT.
// Backpressure: rx has none (bytes arriving outside IDLE/LOAD are dropped, err_overrun set); tx is valid/ready.
// Ports: clk, rst (async, active-high); rx_data/rx_valid strobe in; tx_data/tx_valid/tx_ready out;
//        cp_din/cp_din_valid/cp_dout/cp_control/cp_rst to the coprocessor; busy, err_overrun status.
module coproc_sequencer
    import coproc_sequencer_pkg::*;
#(
    parameter int WIDTH_DIN  = 128,
    parameter int WIDTH_DOUT = 128,
    parameter int PIPE_LAT   = 4,
    parameter int CTRL_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [WIDTH_DIN-1:0]  cp_din,
    output logic                  cp_din_valid,
    input  logic [WIDTH_DOUT-1:0] cp_dout,
    output logic [CTRL_W-1:0]     cp_control,
    output logic                  cp_rst,
    output logic                  busy,
    output logic                  err_overrun
);

    localparam int CNT_W = cnt_width(WIDTH_DIN, WIDTH_DOUT, PIPE_LAT);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(WIDTH_DIN / 8 - 1);
    // WAIT lasts PIPE_LAT-1 cycles; unused when PIPE_LAT == 1 (ISSUE goes straight to CAPTURE)
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((PIPE_LAT > 1) ? PIPE_LAT - 2 : 0);
    // CLEAR holds for two cycles so cp_rst is a 2-cycle pulse
    localparam logic [CNT_W-1:0] LAST_CLR  = CNT_W'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH_DIN-1:0]  din_q, din_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [WIDTH_DOUT-1:0] result_q, result_d;
    logic                  err_q, err_d;
    logic                  din_vld_q, din_vld_d;
    logic                  cp_rst_q, cp_rst_d;
    logic                  ser_load;
    logic                  ser_done;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        err_d    = err_q;
        ser_load = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data[7:6])
                        OP_SETCTL: ctrl_d = rx_data[CTRL_W-1:0];
                        OP_DATA:   state_d = ST_LOAD;
                        OP_READ: begin
                            state_d  = ST_SEND;
                            ser_load = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                            err_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (rx_valid) begin
                    din_d = (din_q << 8) | WIDTH_DIN'(rx_data);
                    if (cnt_q == LAST_IN) begin
                        state_d = ST_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = (PIPE_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                result_d = cp_dout;
                state_d  = ST_IDLE;
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_CLR) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bytes are judged against the state they arrive in, never the next one
        if (rx_valid && (state_q != ST_IDLE) && (state_q != ST_LOAD)) begin
            err_d = 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        din_vld_d = (state_d == ST_ISSUE);
        cp_rst_d  = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            din_q     <= '0;
            ctrl_q    <= CTRL_W'(CTRL_RESET);
            result_q  <= '0;
            err_q     <= 1'b0;
            din_vld_q <= 1'b0;
            cp_rst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            ctrl_q    <= ctrl_d;
            result_q  <= result_d;
            err_q     <= err_d;
            din_vld_q <= din_vld_d;
            cp_rst_q  <= cp_rst_d;
        end
    end

    coproc_sequencer_byte_serializer #(
        .WIDTH (WIDTH_DOUT)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .load_dat (result_q),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

    assign cp_din       = din_q;
    assign cp_din_valid = din_vld_q;
    assign cp_control   = ctrl_q;
    assign cp_rst       = cp_rst_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_overrun  = err_q;

endmodule
